// File: rtl/coin_input_shaper.sv
// Debounces coin/start buttons, queues coin presses and replays each as a fixed-width
// pulse followed by a forced gap. Coin sequencing freezes while paused; debounce does not.
module coin_input_shaper #(
    parameter int DEB_CYC   = 120000,
    parameter int PULSE_CYC = 1200000,
    parameter int GAP_CYC   = 1200000,
    parameter int QMAX      = 3
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic       paused,
    input  logic [1:0] coin_in,
    input  logic [1:0] start_in,
    output logic [1:0] coin_out,
    output logic [1:0] start_out,
    output logic [1:0] coin_busy
);

    localparam int DEB_W   = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
    localparam int CTR_MAX = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
    localparam int CTR_W   = (CTR_MAX > 1) ? $clog2(CTR_MAX) : 1;
    localparam int Q_W     = $clog2(QMAX + 1);

    localparam logic [DEB_W-1:0] DEB_LAST   = DEB_W'(DEB_CYC - 1);
    localparam logic [CTR_W-1:0] PULSE_LAST = CTR_W'(PULSE_CYC - 1);
    localparam logic [CTR_W-1:0] GAP_LAST   = CTR_W'(GAP_CYC - 1);
    localparam logic [Q_W-1:0]   Q_FULL     = Q_W'(QMAX);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } state_t;

    // Assert asynchronously, release two clocks after reset_n rises.
    logic [1:0] rst_pipe;
    logic       rst_n;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            rst_pipe <= 2'b00;
        end else begin
            rst_pipe <= {rst_pipe[0], 1'b1};
        end
    end

    assign rst_n = rst_pipe[1];

    // ---- debounce: lines [1:0] = coin, [3:2] = start ----
    logic [3:0]       raw;
    logic [3:0]       sync_p0;
    logic [3:0]       sync_p1;
    logic [3:0]       stable;
    logic [1:0]       coin_stable_d;
    logic [DEB_W-1:0] deb_cnt [4];
    logic [1:0]       coin_rise;

    assign raw = {start_in, coin_in};

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0       <= '0;
            sync_p1       <= '0;
            stable        <= '0;
            coin_stable_d <= '0;
            for (int i = 0; i < 4; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            sync_p0       <= raw;
            sync_p1       <= sync_p0;
            coin_stable_d <= stable[1:0];
            for (int i = 0; i < 4; i++) begin
                if (sync_p1[i] != stable[i]) begin
                    if (deb_cnt[i] == DEB_LAST) begin
                        stable[i]  <= sync_p1[i];
                        deb_cnt[i] <= '0;
                    end else begin
                        deb_cnt[i] <= deb_cnt[i] + DEB_W'(1);
                    end
                end else begin
                    deb_cnt[i] <= '0;
                end
            end
        end
    end

    assign coin_rise = stable[1:0] & ~coin_stable_d;
    assign start_out = stable[3:2];

    // ---- coin queue and pulse/gap sequencer, one per channel ----
    state_t           state    [2];
    state_t           state_nx [2];
    logic [CTR_W-1:0] ctr      [2];
    logic [CTR_W-1:0] ctr_nx   [2];
    logic [Q_W-1:0]   q        [2];
    logic [Q_W-1:0]   q_nx     [2];
    logic [1:0]       deq;

    always_comb begin
        deq = 2'b00;
        for (int ch = 0; ch < 2; ch++) begin
            state_nx[ch] = state[ch];
            ctr_nx[ch]   = ctr[ch];
            q_nx[ch]     = q[ch];

            case (state[ch])
                IDLE: begin
                    if ((q[ch] != '0) && !paused) begin
                        state_nx[ch] = PULSE;
                        ctr_nx[ch]   = '0;
                        deq[ch]      = 1'b1;
                    end
                end
                PULSE: begin
                    if (!paused) begin
                        if (ctr[ch] == PULSE_LAST) begin
                            state_nx[ch] = GAP;
                            ctr_nx[ch]   = '0;
                        end else begin
                            ctr_nx[ch] = ctr[ch] + CTR_W'(1);
                        end
                    end
                end
                GAP: begin
                    if (!paused) begin
                        if (ctr[ch] == GAP_LAST) begin
                            state_nx[ch] = IDLE;
                            ctr_nx[ch]   = '0;
                        end else begin
                            ctr_nx[ch] = ctr[ch] + CTR_W'(1);
                        end
                    end
                end
                default: begin
                    state_nx[ch] = IDLE;
                    ctr_nx[ch]   = '0;
                end
            endcase

            // A press landing on the dequeue cycle simply replaces the credit taken.
            if (coin_rise[ch] && !deq[ch]) begin
                if (q[ch] != Q_FULL) begin
                    q_nx[ch] = q[ch] + Q_W'(1);
                end
            end else if (deq[ch] && !coin_rise[ch]) begin
                q_nx[ch] = q[ch] - Q_W'(1);
            end
        end
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            coin_out <= 2'b00;
            for (int ch = 0; ch < 2; ch++) begin
                state[ch] <= IDLE;
                ctr[ch]   <= '0;
                q[ch]     <= '0;
            end
        end else begin
            for (int ch = 0; ch < 2; ch++) begin
                state[ch]    <= state_nx[ch];
                ctr[ch]      <= ctr_nx[ch];
                q[ch]        <= q_nx[ch];
                coin_out[ch] <= (state_nx[ch] == PULSE);
            end
        end
    end

    always_comb begin
        coin_busy = 2'b00;
        for (int ch = 0; ch < 2; ch++) begin
            coin_busy[ch] = (q[ch] != '0) || (state[ch] != IDLE);
        end
    end

endmodule
